// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
//   Shared definitions for the DDS reset path and the DDS channel cores:
//   the per-channel reset FSM state encoding and the default parameter values.
//   No ports (package).
// ---------------------------------------------------------------------------
package dds_pkg;

   // Per-channel reset sequencer states. dds_rst is low only in ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2,
      ST_ALIGN  = 2'd3
   } dds_rst_state_t;

   localparam int DDS_NCH_DEF            = 2;
   localparam int DDS_SYNC_STAGES_DEF    = 2;
   localparam int DDS_MIN_RST_CYCLES_DEF = 16;
   localparam int DDS_ALIGN_EN_DEF       = 1;

endpackage : dds_pkg

// File: rtl/bit_synchronizer.sv
// ---------------------------------------------------------------------------
// bit_synchronizer
//   Multi-flop synchronizer for independent level signals. Each bit is
//   synchronized separately; no coherency between bits is implied.
// Ports
//   clk      in   1      destination clock
//   reset_n  in   1      asynchronous active-low clear (all stages to 0)
//   i_d      in   WIDTH  asynchronous inputs
//   o_q      out  WIDTH  synchronized outputs (last stage)
// STAGES must be >= 2.
// ---------------------------------------------------------------------------
module bit_synchronizer #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/dds_reset_sequencer.sv
// ---------------------------------------------------------------------------
// dds_reset_sequencer
//   Converts level reset requests from the CPU-clocked PIO into minimum-width
//   per-channel resets in the DDS sample clock domain. With ALIGN_EN=1 all
//   channels waiting to leave reset are released on the same edge so the
//   phase accumulators restart phase-aligned.
// Ports
//   clk          in   1    DDS sample clock
//   reset_n      in   1    asynchronous active-low reset
//   i_req_async  in   NCH  level reset request per channel (async to clk)
//   o_dds_rst    out  NCH  active-high reset per DDS channel (flop output)
//   o_rel_pulse  out  NCH  1-cycle pulse on the first cycle dds_rst is low again
//   o_busy       out  1    high while any channel FSM is not idle (registered)
// ---------------------------------------------------------------------------
module dds_reset_sequencer
   import dds_pkg::*;
#(
   parameter int NCH            = DDS_NCH_DEF,
   parameter int SYNC_STAGES    = DDS_SYNC_STAGES_DEF,
   parameter int MIN_RST_CYCLES = DDS_MIN_RST_CYCLES_DEF,
   parameter int ALIGN_EN       = DDS_ALIGN_EN_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] i_req_async,
   output logic [NCH-1:0] o_dds_rst,
   output logic [NCH-1:0] o_rel_pulse,
   output logic           o_busy
);

   localparam int            CW       = $clog2(MIN_RST_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MIN_RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_RST_CYCLES);

   logic [NCH-1:0] w_req_s;
   logic [NCH-1:0] w_blocking;    // channel in ASSERT or HOLD this cycle
   logic [NCH-1:0] w_active_nxt;  // channel not idle after this edge
   logic           w_rel_ok;
   logic           r_busy;

   bit_synchronizer #(
      .WIDTH  (NCH),
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (i_req_async),
      .o_q     (w_req_s)
   );

   // Barrier: a channel still asserting or held stalls every waiting channel.
   assign w_rel_ok = (ALIGN_EN != 0) ? ~|w_blocking : 1'b1;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         dds_rst_state_t r_state, w_state_nxt;
         logic [CW-1:0]  r_cnt, w_cnt_nxt;
         logic           r_dds_rst;
         logic           r_rel_pulse;

         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
               ST_IDLE: begin
                  if (w_req_s[g]) begin
                     w_state_nxt = ST_ASSERT;
                     w_cnt_nxt   = '0;
                  end
               end
               ST_ASSERT: begin
                  // Counter saturates; exit compare uses the pre-increment value
                  // so ASSERT lasts exactly MIN_RST_CYCLES cycles.
                  if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
                  if (r_cnt == CNT_LAST)
                     w_state_nxt = w_req_s[g] ? ST_HOLD : ST_ALIGN;
               end
               ST_HOLD: begin
                  if (!w_req_s[g]) w_state_nxt = ST_ALIGN;
               end
               ST_ALIGN: begin
                  // A fresh request wins over a release on the same edge.
                  if (w_req_s[g])    w_state_nxt = ST_HOLD;
                  else if (w_rel_ok) w_state_nxt = ST_IDLE;
               end
               default: w_state_nxt = ST_ASSERT;
            endcase
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_state     <= ST_ASSERT;
               r_cnt       <= '0;
               r_dds_rst   <= 1'b1;
               r_rel_pulse <= 1'b0;
            end else begin
               r_state     <= w_state_nxt;
               r_cnt       <= w_cnt_nxt;
               r_dds_rst   <= (w_state_nxt != ST_IDLE);
               r_rel_pulse <= (r_state == ST_ALIGN) && (w_state_nxt == ST_IDLE);
            end
         end

         assign w_blocking[g]   = (r_state == ST_ASSERT) || (r_state == ST_HOLD);
         assign w_active_nxt[g] = (w_state_nxt != ST_IDLE);
         assign o_dds_rst[g]    = r_dds_rst;
         assign o_rel_pulse[g]  = r_rel_pulse;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_busy <= 1'b1;
      else          r_busy <= |w_active_nxt;
   end

   assign o_busy = r_busy;

endmodule : dds_reset_sequencer

// File: tb/tb_dds_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dds_reset_sequencer
//   Drives two sequencers (barrier on / barrier off) with the same directed
//   and random request sequences and checks every cycle against a reference
//   model described in terms of "time spent in reset" per channel.
// ---------------------------------------------------------------------------
module tb_dds_reset_sequencer;

   localparam int NCH  = 2;
   localparam int SYNC = 2;
   localparam int MIN  = 16;

   logic           clk;
   logic           reset_n;
   logic [NCH-1:0] req;
   logic [NCH-1:0] rst_a, pul_a, rst_n0, pul_n0;
   logic           busy_a, busy_n0;

   int n_vec = 0;
   int n_err = 0;
   int hi_a0 = 0;   // sampled cycles with dds_rst[0] high on the barrier DUT

   dds_reset_sequencer #(
      .NCH(NCH), .SYNC_STAGES(SYNC), .MIN_RST_CYCLES(MIN), .ALIGN_EN(1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .i_req_async(req),
      .o_dds_rst(rst_a), .o_rel_pulse(pul_a), .o_busy(busy_a)
   );

   dds_reset_sequencer #(
      .NCH(NCH), .SYNC_STAGES(SYNC), .MIN_RST_CYCLES(MIN), .ALIGN_EN(0)
   ) dut_n (
      .clk(clk), .reset_n(reset_n), .i_req_async(req),
      .o_dds_rst(rst_n0), .o_rel_pulse(pul_n0), .o_busy(busy_n0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model --------------------------------------
   // Index 0 = barrier model, 1 = independent model.
   // in_rst : channel holds its reset
   // age    : edges spent asserting since the reset began (stops mattering at MIN)
   // last   : request seen at the previous edge (a held request keeps it in reset)
   logic [NCH-1:0] m_dly [SYNC];
   bit             m_rst   [2][NCH];
   int             m_age   [2][NCH];
   bit             m_last  [2][NCH];
   bit             m_pulse [2][NCH];

   task automatic model_reset();
      for (int k = 0; k < SYNC; k++) m_dly[k] = '0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NCH; i++) begin
            m_rst[d][i] = 1; m_age[d][i] = 0; m_last[d][i] = 0; m_pulse[d][i] = 0;
         end
   endtask

   task automatic model_edge(input logic [NCH-1:0] a);
      logic [NCH-1:0] rs;
      bit stall, ok;
      rs = m_dly[SYNC-1];               // request as seen SYNC edges late
      for (int k = SYNC-1; k > 0; k--) m_dly[k] = m_dly[k-1];
      m_dly[0] = a;
      for (int d = 0; d < 2; d++) begin
         stall = 0;
         for (int i = 0; i < NCH; i++)
            if (m_rst[d][i] && (m_age[d][i] < MIN || m_last[d][i])) stall = 1;
         ok = (d == 0) ? !stall : 1'b1;
         for (int i = 0; i < NCH; i++) begin
            m_pulse[d][i] = 0;
            if (!m_rst[d][i]) begin
               if (rs[i]) begin m_rst[d][i] = 1; m_age[d][i] = 0; end
            end else if (m_age[d][i] < MIN) begin
               m_age[d][i]++;
            end else if (!m_last[d][i] && !rs[i] && ok) begin
               m_rst[d][i] = 0; m_pulse[d][i] = 1;
            end
            m_last[d][i] = rs[i];
         end
      end
   endtask

   // ---------------- checking ---------------------------------------------
   task automatic check(input string tag, input logic [NCH-1:0] obs,
                        input logic [NCH-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [NCH-1:0] er [2];
      logic [NCH-1:0] ep [2];
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NCH; i++) begin
            er[d][i] = m_rst[d][i];
            ep[d][i] = m_pulse[d][i];
         end
      check("align.dds_rst",   rst_a,  er[0]);
      check("align.rel_pulse", pul_a,  ep[0]);
      check("align.busy",      {{(NCH-1){1'b0}}, busy_a},  {{(NCH-1){1'b0}}, |er[0]});
      check("indep.dds_rst",   rst_n0, er[1]);
      check("indep.rel_pulse", pul_n0, ep[1]);
      check("indep.busy",      {{(NCH-1){1'b0}}, busy_n0}, {{(NCH-1){1'b0}}, |er[1]});
   endtask

   // One clock: model sees the request that was stable before the edge.
   task automatic tick();
      @(posedge clk);
      if (reset_n) model_edge(req);
      #1;
      compare_all();
      if (rst_a[0]) hi_a0++;
   endtask

   task automatic run(input logic [NCH-1:0] r, input int n);
      req = r;
      repeat (n) tick();
   endtask

   // Asserted between edges; dds_rst must go high without waiting for clk.
   task automatic apply_reset(input int n);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst.dds_rst", rst_a, '1);
      check("async_rst.busy", {{(NCH-1){1'b0}}, busy_a}, {{(NCH-1){1'b0}}, 1'b1});
      compare_all();
      repeat (n) tick();
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ---------------------------------------------
   initial begin
      reset_n = 1'b1;
      req     = '0;
      model_reset();
      #2;

      // Power-on: the deassert-to-first-edge partial cycle is not sampled,
      // so 16 samples here make up the 17-cycle minimum reset.
      apply_reset(5);
      hi_a0 = 0;
      run(2'b00, 25);
      check_int("poweron_width", hi_a0, MIN);

      // Single short request on channel 0.
      hi_a0 = 0;
      run(2'b01, 3);
      run(2'b00, 25);
      check_int("short_req_width", hi_a0, MIN + 1);

      // Long hold: reset lasts until two edges after the synced request falls.
      hi_a0 = 0;
      run(2'b01, 40);
      run(2'b00, 25);
      check_int("long_hold_width", hi_a0, 40 + 1);

      // Barrier vs independent release, same stimulus on both DUTs.
      run(2'b01, 3);
      run(2'b00, 2);
      run(2'b10, 50);
      run(2'b00, 30);

      // Re-request landing on the ALIGN cycle, then reset while in HOLD.
      run(2'b01, 3);
      run(2'b00, 14);
      run(2'b01, 4);
      check("rereq.hold_dds_rst", rst_a, 2'b01);
      apply_reset(2);
      run(2'b00, 25);

      // Random request levels honouring the stability contract, with
      // occasional mid-operation resets.
      repeat (150) begin
         run(2'($urandom_range(0, 3)), $urandom_range(SYNC + 1, 30));
         if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 4));
      end
      run(2'b00, 25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dds_reset_sequencer
